// File: rtl/ro_buffer.sv
// ro_buffer: circular reorder buffer with in-order commit, operand bypass and mispredict flush.
module ro_buffer #(
  parameter int ROB_SIZE = 16,
  parameter int ID_W = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            rdy,
  input  logic            valid_from_issuer,
  input  logic [4:0]      rd_from_issuer,
  input  logic            is_branch_from_issuer,
  input  logic [31:0]     pred_pc_from_issuer,
  output logic [ID_W-1:0] next_id_to_issuer,
  input  logic [ID_W-1:0] qj_from_issuer,
  input  logic [ID_W-1:0] qk_from_issuer,
  output logic            qj_ready_to_issuer,
  output logic            qk_ready_to_issuer,
  output logic [31:0]     vj_to_issuer,
  output logic [31:0]     vk_to_issuer,
  input  logic [ID_W-1:0] dest_from_rss_bus,
  input  logic [31:0]     value_from_rss_bus,
  input  logic [31:0]     next_pc_from_rss_bus,
  input  logic [ID_W-1:0] dest_from_lsb_bus,
  input  logic [31:0]     value_from_lsb_bus,
  output logic [4:0]      rd_to_reg_file,
  output logic [ID_W-1:0] dest_to_reg_file,
  output logic [31:0]     value_to_reg_file,
  output logic            reset_to_rob_bus,
  output logic [31:0]     pc_to_inst_fetcher,
  output logic            is_ro_buffer_full
);
  logic [ID_W-1:0] head, tail, size;
  logic            busy  [0:ROB_SIZE];
  logic            ready [0:ROB_SIZE];
  logic            is_br [0:ROB_SIZE];
  logic [4:0]      rd    [0:ROB_SIZE];
  logic [31:0]     val   [0:ROB_SIZE];
  logic [31:0]     npc   [0:ROB_SIZE];
  logic [31:0]     ppc   [0:ROB_SIZE];
  logic            alloc, commit, mispred;
  function automatic logic [ID_W-1:0] nxt(input logic [ID_W-1:0] x);
    return x == ID_W'(ROB_SIZE) ? ID_W'(1) : x + ID_W'(1);
  endfunction
  // Stored value wins; otherwise bypass whichever result bus carries the id this cycle.
  function automatic logic [32:0] query(input logic [ID_W-1:0] q);
    return q == '0 ? {1'b1, 32'h0} :
           busy[q] && ready[q] ? {1'b1, val[q]} :
           q == dest_from_rss_bus ? {1'b1, value_from_rss_bus} :
           q == dest_from_lsb_bus ? {1'b1, value_from_lsb_bus} : 33'h0;
  endfunction
  assign {qj_ready_to_issuer, vj_to_issuer} = query(qj_from_issuer);
  assign {qk_ready_to_issuer, vk_to_issuer} = query(qk_from_issuer);
  assign next_id_to_issuer = tail;
  assign is_ro_buffer_full = size >= ID_W'(ROB_SIZE - 1);
  assign alloc   = valid_from_issuer && size != ID_W'(ROB_SIZE);
  assign commit  = busy[head] && ready[head];
  assign mispred = is_br[head] && npc[head] != ppc[head];
  // A pending flush returns the buffer to exactly its reset state.
  always_ff @(posedge clk) begin
    if (rst || (rdy && reset_to_rob_bus)) begin
      head <= ID_W'(1);
      tail <= ID_W'(1);
      size <= '0;
      for (int i = 0; i <= ROB_SIZE; i++) begin
        busy[i]  <= 1'b0;
        ready[i] <= 1'b0;
      end
      rd_to_reg_file     <= '0;
      dest_to_reg_file   <= '0;
      value_to_reg_file  <= '0;
      reset_to_rob_bus   <= 1'b0;
      pc_to_inst_fetcher <= '0;
    end else if (rdy) begin
      if (dest_from_rss_bus != '0 && busy[dest_from_rss_bus]) begin
        val[dest_from_rss_bus]   <= value_from_rss_bus;
        npc[dest_from_rss_bus]   <= next_pc_from_rss_bus;
        ready[dest_from_rss_bus] <= 1'b1;
      end
      if (dest_from_lsb_bus != '0 && busy[dest_from_lsb_bus]) begin
        val[dest_from_lsb_bus]   <= value_from_lsb_bus;
        ready[dest_from_lsb_bus] <= 1'b1;
      end
      if (commit) begin
        busy[head]  <= 1'b0;
        ready[head] <= 1'b0;
        head        <= nxt(head);
      end
      if (alloc) begin
        busy[tail]  <= 1'b1;
        ready[tail] <= 1'b0;
        rd[tail]    <= rd_from_issuer;
        is_br[tail] <= is_branch_from_issuer;
        ppc[tail]   <= pred_pc_from_issuer;
        tail        <= nxt(tail);
      end
      size               <= size + ID_W'(alloc) - ID_W'(commit);
      rd_to_reg_file     <= commit ? rd[head] : 5'd0;
      dest_to_reg_file   <= commit ? head : '0;
      value_to_reg_file  <= commit ? val[head] : 32'h0;
      reset_to_rob_bus   <= commit && mispred;
      pc_to_inst_fetcher <= commit && mispred ? npc[head] : 32'h0;
    end
  end
endmodule

// File: doc/ro_buffer.md
RO_BUFFER -- requirements
Module: ro_buffer

Interface
REQ-001 SHALL have these parameters (name, default, meaning):
  ROB_SIZE, 16, number of entries; valid ids are 1..16 and id 0 means "none"
  ID_W, 5, width of a reorder-buffer id
REQ-002 SHALL have these ports (name, direction, width, meaning); clk and rst come first:
  clk  in  1  clock; all state changes on the rising edge
  rst  in  1  synchronous, active-high reset
  rdy  in  1  global enable; when 0, all state and outputs hold
  valid_from_issuer  in  1  allocate the entry at tail this cycle
  rd_from_issuer  in  5  destination register; 0 means no register write
  is_branch_from_issuer  in  1  entry is a branch or jump
  pred_pc_from_issuer  in  32  predicted next pc
  next_id_to_issuer  out  ID_W  id that the next allocation receives (combinational)
  qj_from_issuer, qk_from_issuer  in  ID_W  operand ids to query
  qj_ready_to_issuer, qk_ready_to_issuer  out  1  queried entry has its value (combinational)
  vj_to_issuer, vk_to_issuer  out  32  queried value (combinational)
  dest_from_rss_bus  in  ID_W  ALU result id; 0 means idle
  value_from_rss_bus, next_pc_from_rss_bus  in  32  ALU result value and resolved next pc
  dest_from_lsb_bus  in  ID_W  load/store result id; 0 means idle
  value_from_lsb_bus  in  32  load result value
  rd_to_reg_file  out  5  committed register; 0 means no write
  dest_to_reg_file  out  ID_W  id of the committed entry; 0 means no commit
  value_to_reg_file  out  32  committed value
  reset_to_rob_bus  out  1  one-cycle mispredict flush
  pc_to_inst_fetcher  out  32  redirect target, valid while reset_to_rob_bus=1
  is_ro_buffer_full  out  1  issuer must not allocate

Function
REQ-003 SHALL be a circular buffer with registered head, tail and size; tail advances 16 -> 1 on wrap, and head advances the same way.
REQ-004 On an allocation, the entry at tail SHALL be marked busy and not-ready, storing rd, is_branch and pred_pc; tail SHALL advance and next_id_to_issuer SHALL equal tail.
REQ-005 is_ro_buffer_full SHALL equal (size >= ROB_SIZE-1), a pre-full margin of one entry; an allocation while size == ROB_SIZE SHALL be ignored.
REQ-006 When dest_from_rss_bus != 0 and that entry is busy, the entry SHALL store value and next_pc and be marked ready.
REQ-007 When dest_from_lsb_bus != 0 and that entry is busy, the entry SHALL store value and be marked ready.
REQ-008 Both buses SHALL be captured in the same cycle when their ids differ.
REQ-009 A bus id naming a non-busy entry SHALL be ignored.
REQ-010 A query SHALL report ready=1 with the stored value when the entry is busy and ready.
REQ-011 A query SHALL otherwise report ready=1 with the bus value when the id matches the rss bus this cycle; else when it matches the lsb bus this cycle; else ready=0 and value 0.
REQ-012 A query id of 0 SHALL report ready=1 and value 0.
REQ-013 Commit: when the head entry is busy and ready, it SHALL retire on that edge. Registered outputs SHALL be dest_to_reg_file=head id, rd_to_reg_file=rd and value_to_reg_file=value. Head SHALL advance and the entry SHALL be cleared.
REQ-014 At most one commit SHALL occur per cycle; in a cycle with no commit, dest_to_reg_file, rd_to_reg_file and value_to_reg_file SHALL be 0.
REQ-015 A bus write reaching the head entry at edge N SHALL commit at edge N+1, so the head entry retires no earlier than one cycle after its result arrives.
REQ-016 A committing branch whose next_pc != pred_pc SHALL still commit its rd/value (link register). It SHALL also drive reset_to_rob_bus=1 and pc_to_inst_fetcher=next_pc for exactly one cycle.
REQ-017 On the edge after a mispredict commit, the buffer SHALL clear to the reset state, and allocations and bus writes in that cycle SHALL be discarded.
REQ-018 A committing branch with next_pc == pred_pc SHALL leave reset_to_rob_bus=0.
REQ-019 When an allocation and a commit occur in the same cycle, size SHALL be unchanged; otherwise size SHALL change by +1 for an allocation and -1 for a commit.

Reset
REQ-020 When rst=1 at an edge, the block SHALL set head=tail=1 and size=0, clear all busy and ready flags, and set every registered output to 0. rst SHALL override rdy and all inputs, including mid-flush.

Verification
REQ-021 Reset, then allocate 3 entries with rd=5,6,7, then write ids 1..3 on the rss bus with value 0x11,0x22,0x33 -> commits in order, (id1,rd5,0x11) first, one per cycle.
REQ-022 Allocate ids 1 and 2; write id 2 via the lsb bus before id 1 -> no commit until id 1 is written; then id 1 and id 2 commit on consecutive cycles.
REQ-023 Allocate a branch with pred_pc=0x100; it resolves with next_pc=0x200 -> reset_to_rob_bus=1 and pc_to_inst_fetcher=0x200 for one cycle; the next cycle size=0 and next_id_to_issuer=1.
REQ-024 Fill to 15 entries -> is_ro_buffer_full=1; commit one while allocating one -> size stays 15; run 40 allocate/commit pairs -> ids wrap 16 -> 1 correctly.
REQ-025 Query id 4 in the same cycle the rss bus carries id 4 with value 0xAB -> qj_ready_to_issuer=1 and vj_to_issuer=0xAB.
REQ-026 Drive rdy=0 for 3 cycles while bus inputs are active -> no state change; drive rst mid-stream -> all outputs read 0 on the next cycle.
